// File: rtl/accel_cmd_wrapper_if.sv
// Bus bundle for accel_cmd_wrapper: ARM ports, BRAM/DMA data path, accelerator core, LEDs.
// The wrapper uses the slave modport; the host/system side uses master.
interface accel_cmd_wrapper_if #(
    parameter int DATA_W = 1024
);
    logic [DATA_W-1:0] bram_din;
    logic              bram_din_valid;
    logic [DATA_W-1:0] bram_dout;
    logic              bram_dout_valid;
    logic              bram_dout_read;
    logic [31:0]       port1_din;
    logic              port1_valid;
    logic              port1_read;
    logic [31:0]       port2_dout;
    logic              port2_valid;
    logic              port2_read;
    logic              accel_start;
    logic [DATA_W-1:0] accel_din_a;
    logic [DATA_W-1:0] accel_din_b;
    logic [DATA_W-1:0] accel_dout;
    logic              accel_done;
    logic [3:0]        leds;

    modport slave (
        input  bram_din, bram_din_valid, bram_dout_read,
        input  port1_din, port1_valid, port2_read,
        input  accel_dout, accel_done,
        output bram_dout, bram_dout_valid, port1_read,
        output port2_dout, port2_valid,
        output accel_start, accel_din_a, accel_din_b, leds
    );

    modport master (
        output bram_din, bram_din_valid, bram_dout_read,
        output port1_din, port1_valid, port2_read,
        output accel_dout, accel_done,
        input  bram_dout, bram_dout_valid, port1_read,
        input  port2_dout, port2_valid,
        input  accel_start, accel_din_a, accel_din_b, leds
    );
endinterface

// File: rtl/accel_cmd_wrapper.sv
// Command front-end: register bank, opcode decode, accelerator sequencing, status on port2.
// Optional ACCEL_TIMEOUT_EN adds TIMEOUT_CYCLES and a COMPUTE_WAIT watchdog.
module accel_cmd_wrapper #(
    parameter int DATA_W   = 1024,
    parameter int NUM_REGS = 4,
    parameter int CNT_W    = 16
`ifdef ACCEL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input logic clk,
    input logic reset,
    accel_cmd_wrapper_if.slave bus
);
    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_CSTART = 3'd3;
    localparam logic [2:0] S_CWAIT  = 3'd4;
    localparam logic [2:0] S_WDATA  = 3'd5;
    localparam logic [2:0] S_WP2    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [15:0]       cmd_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q;
    logic              err_op_q, err_idx_q, err_to_q, sticky_q;

    logic [3:0]        op, dst, src_a, src_b;
    logic              op_bad, idx_bad, tmo_hit, to_ev, err_ev;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data, rd_a, rd_b;
    logic [15:0]       cnt16;
    logic              ok;
    logic              unused_hi;

    assign op     = cmd_q[3:0];
    assign dst    = cmd_q[7:4];
    assign src_a  = cmd_q[11:8];
    assign src_b  = cmd_q[15:12];
    assign op_bad = op > 4'd3;

    assign unused_hi = ^bus.port1_din[31:16];

    function automatic logic oob(input logic [3:0] i);
        return 32'(i) >= NUM_REGS;
    endfunction

    always_comb begin
        idx_bad = 1'b0;
        case (op)
            4'd0:    idx_bad = oob(dst);
            4'd1:    idx_bad = oob(dst) | oob(src_a) | oob(src_b);
            4'd2:    idx_bad = oob(src_a);
            default: idx_bad = 1'b0;
        endcase
    end

    // Out-of-range indices read as zero rather than X
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_a == 4'(i)) rd_a = regs_q[i];
            if (src_b == 4'(i)) rd_b = regs_q[i];
        end
    end

`ifdef ACCEL_TIMEOUT_EN
    logic [31:0] tmo_q;

    assign tmo_hit = tmo_q == 32'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset || state_q != S_CWAIT) tmo_q <= '0;
        else                             tmo_q <= tmo_q + 32'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign to_ev   = (state_q == S_CWAIT) && !bus.accel_done && tmo_hit;
    assign err_ev  = ((state_q == S_DECODE) && (op_bad || idx_bad)) || to_ev;
    assign wr_en   = ((state_q == S_READ) && bus.bram_din_valid) ||
                     ((state_q == S_CWAIT) && bus.accel_done);
    assign wr_data = (state_q == S_READ) ? bus.bram_din : bus.accel_dout;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (bus.port1_valid) state_d = S_DECODE;
            S_DECODE: begin
                if (op_bad || idx_bad) state_d = S_WP2;
                else begin
                    case (op)
                        4'd0:    state_d = S_READ;
                        4'd1:    state_d = S_CSTART;
                        4'd2:    state_d = S_WDATA;
                        default: state_d = S_WP2;
                    endcase
                end
            end
            S_READ:   if (bus.bram_din_valid) state_d = S_WP2;
            S_CSTART: state_d = S_CWAIT;
            S_CWAIT:  if (bus.accel_done || tmo_hit) state_d = S_WP2;
            S_WDATA:  if (bus.bram_dout_read) state_d = S_WP2;
            S_WP2:    if (bus.port2_read) state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT;
            cmd_q     <= '0;
            cnt_q     <= '0;
            err_op_q  <= 1'b0;
            err_idx_q <= 1'b0;
            err_to_q  <= 1'b0;
            sticky_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && bus.port1_valid)
                cmd_q <= bus.port1_din[15:0];
            if (wr_en) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (dst == 4'(i)) regs_q[i] <= wr_data;
            end
            if (state_q == S_DECODE) begin
                if (op_bad)       err_op_q  <= 1'b1;
                else if (idx_bad) err_idx_q <= 1'b1;
            end
            if (to_ev) err_to_q <= 1'b1;
            if (err_ev) sticky_q <= 1'b1;
            if (state_q == S_WP2 && bus.port2_read) begin
                cnt_q     <= cnt_q + CNT_W'(1);
                err_op_q  <= 1'b0;
                err_idx_q <= 1'b0;
                err_to_q  <= 1'b0;
            end
        end
    end

    assign cnt16 = 16'(cnt_q);
    assign ok    = ~(err_op_q | err_idx_q | err_to_q);

    assign bus.port1_read      = state_q == S_DECODE;
    assign bus.accel_start     = state_q == S_CSTART;
    assign bus.bram_dout_valid = state_q == S_WDATA;
    assign bus.port2_valid     = state_q == S_WP2;
    assign bus.port2_dout      = (state_q == S_WP2) ?
        {cnt16, 12'h000, err_to_q, err_idx_q, err_op_q, ok} : 32'h0;
    assign bus.bram_dout       = rd_a;
    assign bus.accel_din_a     = rd_a;
    assign bus.accel_din_b     = rd_b;
    assign bus.leds            = {sticky_q, state_q};
endmodule

// File: tb/tb_accel_cmd_wrapper.sv
// Scoreboard bench for accel_cmd_wrapper: status words queued at issue, checked at port2.
// Build with ACCEL_TIMEOUT_EN to include the watchdog scenario (TIMEOUT_CYCLES=16).
module tb_accel_cmd_wrapper;
    localparam int DW = 1024;
    localparam logic [3:0] E_OK  = 4'b0001;
    localparam logic [3:0] E_OP  = 4'b0010;
    localparam logic [3:0] E_IDX = 4'b0100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    accel_cmd_wrapper_if #(.DATA_W(DW)) ifc ();

`ifdef ACCEL_TIMEOUT_EN
    accel_cmd_wrapper #(.DATA_W(DW), .NUM_REGS(4), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .bus(ifc));
`else
    accel_cmd_wrapper #(.DATA_W(DW), .NUM_REGS(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(ifc));
`endif

    int total = 0;
    int bad = 0;
    int cnt = 0;
    int sent = 0;
    int p1r_cnt = 0;
    int start_cnt = 0;
    logic [31:0] exp_q [$];
    logic [DW-1:0] model [4];

    always @(posedge clk) begin
        if (ifc.port1_read) p1r_cnt <= p1r_cnt + 1;
        if (ifc.accel_start) start_cnt <= start_cnt + 1;
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic send_cmd(input logic [31:0] c, input logic [3:0] e);
        exp_q.push_back({cnt[15:0], 12'h000, e});
        @(negedge clk);
        ifc.port1_din = c;
        ifc.port1_valid = 1'b1;
        @(negedge clk);
        ifc.port1_valid = 1'b0;
        sent++;
        total++;
        if (ifc.port1_read !== 1'b1) begin
            bad++;
            $display("FAIL port1_read cmd=%h got=%b want=1", c, ifc.port1_read);
        end
    endtask

    task automatic get_status(input string nm, input int hold);
        int n;
        logic [31:0] e;
        n = 0;
        while (ifc.port2_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL %s port2_valid timeout got=0 want=1", nm);
        end else begin
            if (ifc.port2_dout !== e) begin
                bad++;
                $display("FAIL %s status got=%h want=%h", nm, ifc.port2_dout, e);
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                total++;
                if (ifc.port2_valid !== 1'b1 || ifc.port2_dout !== e) begin
                    bad++;
                    $display("FAIL %s hold%0d valid=%b got=%h want=%h", nm, i,
                             ifc.port2_valid, ifc.port2_dout, e);
                end
            end
            ifc.port2_read = 1'b1;
            @(negedge clk);
            ifc.port2_read = 1'b0;
            cnt++;
            total++;
            if (ifc.port2_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s port2_valid after read got=%b want=0", nm, ifc.port2_valid);
            end
        end
        total++;
        if (p1r_cnt !== sent) begin
            bad++;
            $display("FAIL %s port1_read pulses got=%0d want=%0d", nm, p1r_cnt, sent);
        end
    endtask

    task automatic do_read(input logic [3:0] dst, input logic [DW-1:0] d);
        ifc.bram_din = d;
        ifc.bram_din_valid = 1'b1;
        send_cmd({16'h0, 8'h00, dst, 4'h0}, E_OK);
        get_status("read", 0);
        ifc.bram_din_valid = 1'b0;
        model[dst[1:0]] = d;
    endtask

    task automatic do_write(input logic [3:0] src, input int hold);
        int n;
        logic [DW-1:0] e;
        e = model[src[1:0]];
        send_cmd({16'h0, 4'h0, src, 8'h02}, E_OK);
        n = 0;
        while (ifc.bram_dout_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL write bram_dout_valid timeout got=0 want=1");
        end else if (ifc.bram_dout !== e) begin
            bad++;
            $display("FAIL write reg%0d data got=%h want=%h", src, ifc.bram_dout[63:0], e[63:0]);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (ifc.bram_dout_valid !== 1'b1 || ifc.bram_dout !== e) begin
                bad++;
                $display("FAIL write_hold%0d valid=%b got=%h want=%h", i,
                         ifc.bram_dout_valid, ifc.bram_dout[63:0], e[63:0]);
            end
        end
        ifc.bram_dout_read = 1'b1;
        @(negedge clk);
        ifc.bram_dout_read = 1'b0;
        get_status("write", hold);
    endtask

    task automatic do_compute(input logic [3:0] dst, input logic [3:0] a, input logic [3:0] b);
        int n, s0;
        logic [DW-1:0] sum;
        s0 = start_cnt;
        sum = model[a[1:0]] + model[b[1:0]];
        send_cmd({16'h0, b, a, dst, 4'h1}, E_OK);
        n = 0;
        while (ifc.accel_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL compute accel_start timeout got=0 want=1");
        end else if (ifc.accel_din_a !== model[a[1:0]] || ifc.accel_din_b !== model[b[1:0]]) begin
            bad++;
            $display("FAIL compute operands got=%h,%h want=%h,%h", ifc.accel_din_a[31:0],
                     ifc.accel_din_b[31:0], model[a[1:0]][31:0], model[b[1:0]][31:0]);
        end
        repeat (3) @(negedge clk);
        ifc.accel_dout = sum;
        ifc.accel_done = 1'b1;
        @(negedge clk);
        ifc.accel_done = 1'b0;
        ifc.accel_dout = rnd_word();
        get_status("compute", 0);
        model[dst[1:0]] = sum;
        total++;
        if (start_cnt - s0 !== 1) begin
            bad++;
            $display("FAIL compute accel_start pulses got=%0d want=1", start_cnt - s0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (ifc.leds !== 4'h0 || ifc.port2_valid !== 1'b0 || ifc.port1_read !== 1'b0 ||
            ifc.bram_dout_valid !== 1'b0 || ifc.accel_start !== 1'b0 ||
            ifc.port2_dout !== 32'h0 || ifc.bram_dout !== '0) begin
            bad++;
            $display("FAIL reset_state leds=%h p2v=%b p2d=%h want all zero",
                     ifc.leds, ifc.port2_valid, ifc.port2_dout);
        end
        reset = 1'b0;
    endtask

    task automatic test_read_write();
        do_read(4'd1, rnd_word());
        do_write(4'd1, 0);
    endtask

    task automatic test_compute();
        do_read(4'd0, DW'(5));
        do_read(4'd1, DW'(7));
        do_compute(4'd3, 4'd0, 4'd1);
        do_write(4'd3, 0);
        do_compute(4'd0, 4'd0, 4'd1);
        do_write(4'd0, 0);
    endtask

    task automatic test_errors();
        send_cmd(32'h0000_0007, E_OP);
        get_status("bad_opcode", 0);
        total++;
        if (ifc.leds[3] !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", ifc.leds[3]);
        end
        ifc.bram_din = rnd_word();
        ifc.bram_din_valid = 1'b1;
        send_cmd(32'h0000_0050, E_IDX);
        get_status("bad_idx_read", 0);
        ifc.bram_din_valid = 1'b0;
        send_cmd(32'h0000_0502, E_IDX);
        get_status("bad_idx_write", 0);
        send_cmd(32'h0000_5031, E_IDX);
        get_status("bad_idx_compute", 0);
        do_write(4'd1, 0);
        do_write(4'd3, 0);
        send_cmd(32'hABCD_0003, E_OK);
        get_status("status_op", 0);
        total++;
        if (ifc.leds[3] !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky_kept got=%b want=1", ifc.leds[3]);
        end
    endtask

    task automatic test_backpressure();
        do_write(4'd1, 20);
    endtask

    task automatic test_stray_done();
        @(negedge clk);
        ifc.accel_dout = rnd_word();
        ifc.accel_done = 1'b1;
        @(negedge clk);
        ifc.accel_done = 1'b0;
        total++;
        if (ifc.leds[2:0] !== 3'd0) begin
            bad++;
            $display("FAIL stray_done state got=%0d want=0", ifc.leds[2:0]);
        end
        do_write(4'd3, 0);
    endtask

`ifdef ACCEL_TIMEOUT_EN
    task automatic test_timeout();
        int n, w;
        send_cmd(32'h0000_1031, 4'b1000);
        n = 0;
        w = 0;
        while (ifc.port2_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (ifc.leds[2:0] == 3'd4) w++;
        end
        get_status("timeout", 0);
        total++;
        if (w !== 16) begin
            bad++;
            $display("FAIL timeout cycles got=%0d want=16", w);
        end
        do_write(4'd3, 0);
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        send_cmd(32'h0000_1031, E_OK);
        n = 0;
        while (ifc.leds[2:0] !== 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL reset_mid reach COMPUTE_WAIT got=%0d want=4", ifc.leds[2:0]);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ifc.leds !== 4'h0 || ifc.port2_valid !== 1'b0 || ifc.port2_dout !== 32'h0 ||
            ifc.accel_start !== 1'b0 || ifc.bram_dout !== '0 || ifc.accel_din_a !== '0 ||
            ifc.accel_din_b !== '0 || ifc.port1_read !== 1'b0 || ifc.bram_dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid outputs leds=%h p2v=%b p2d=%h want all zero",
                     ifc.leds, ifc.port2_valid, ifc.port2_dout);
        end
        reset = 1'b0;
        exp_q.delete();
        cnt = 0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ifc.port2_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid port2_valid got=1 want=0");
            end
        end
        do_write(4'd3, 0);
    endtask

    initial begin
        ifc.bram_din = '0;
        ifc.bram_din_valid = 1'b0;
        ifc.bram_dout_read = 1'b0;
        ifc.port1_din = '0;
        ifc.port1_valid = 1'b0;
        ifc.port2_read = 1'b0;
        ifc.accel_dout = '0;
        ifc.accel_done = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        test_reset();
        test_read_write();
        test_compute();
        test_errors();
        test_backpressure();
        test_stray_done();
`ifdef ACCEL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
